mc_main_control: RTL and testbench

//  Multi-cycle MIPS main control FSM. Producer side of the ALUop interface consumed by ALU_control.

---
 rtl/mc_main_control_if.sv | 37 +++
 rtl/mc_main_control.sv | 228 ++++++++++++++++++++++
 tb/tb_mc_main_control.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mc_main_control_if.sv
// Control bus between the multi-cycle MIPS main control FSM and the datapath/memory.
// The controller drives datapath selects and enables; the datapath returns opcode and mem_ready.
interface mc_main_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_eq;
    logic       pc_write_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       bus_timeout;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_eq, pc_write_ne, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
               illegal_op, bus_timeout, state
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_eq, pc_write_ne, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
               illegal_op, bus_timeout, state
    );
endinterface

// File: rtl/mc_main_control.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects and alu_op, and traps on undefined opcodes or memory timeouts.
module mc_main_control #(
    parameter int unsigned WAIT_W   = 8,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    mc_main_control_if.master bus
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAddr = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExec    = 4'd6,
        StRWb     = 4'd7,
        StBranch  = 4'd8,
        StJump    = 4'd9,
        StImmExec = 4'd10,
        StImmWb   = 4'd11,
        StTrap    = 4'd12
    } state_e;

    localparam logic [5:0] OpR     = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpAddiu = 6'b001001;

    localparam logic [WAIT_W-1:0] MaxWaitW  = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] MaxWaitM1 = WAIT_W'(MAX_WAIT - 1);

    state_e            state_q, state_d;
    logic [5:0]        op_q;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              illegal_q, timeout_q;
    logic              illegal_set, timeout_set;
    logic              timeout_hit;

    logic       pc_write, pc_write_eq, pc_write_ne, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;

    function automatic logic is_wait_state(input state_e s);
        return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
    endfunction

    // The counter sits one below MAX_WAIT on the last tolerated idle cycle.
    assign timeout_hit = (MAX_WAIT != 0) && !bus.mem_ready && (wait_cnt_q == MaxWaitM1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StFetch;
            op_q       <= '0;
            wait_cnt_q <= '0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_q | illegal_set;
            timeout_q  <= timeout_q | timeout_set;
            if (state_q == StDecode) begin
                op_q <= bus.opcode;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        illegal_set = 1'b0;
        timeout_set = 1'b0;
        pc_write    = 1'b0;
        pc_write_eq = 1'b0;
        pc_write_ne = 1'b0;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        mem_to_reg  = 1'b0;
        reg_dst     = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        pc_source   = 2'b00;

        case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end else if (timeout_hit) begin
                    state_d     = StTrap;
                    timeout_set = 1'b1;
                end
            end
            StDecode: begin
                alu_src_b = 2'b11;
                case (bus.opcode)
                    OpLw, OpSw:   state_d = StMemAddr;
                    OpR:          state_d = StExec;
                    OpBeq, OpBne: state_d = StBranch;
                    OpJ:          state_d = StJump;
                    OpAddiu:      state_d = StImmExec;
                    default: begin
                        state_d     = StTrap;
                        illegal_set = 1'b1;
                    end
                endcase
            end
            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (op_q == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (bus.mem_ready) begin
                    state_d = StMemWb;
                end else if (timeout_hit) begin
                    state_d     = StTrap;
                    timeout_set = 1'b1;
                end
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (bus.mem_ready) begin
                    state_d = StFetch;
                end else if (timeout_hit) begin
                    state_d     = StTrap;
                    timeout_set = 1'b1;
                end
            end
            StExec: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b11;
                state_d   = StRWb;
            end
            StRWb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                alu_src_a = 1'b1;
                pc_source = 2'b01;
                if (op_q == OpBne) begin
                    alu_op      = 2'b10;
                    pc_write_ne = 1'b1;
                end else begin
                    alu_op      = 2'b01;
                    pc_write_eq = 1'b1;
                end
                state_d = StFetch;
            end
            StJump: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                state_d   = StFetch;
            end
            StImmExec: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = StImmWb;
            end
            StImmWb: begin
                reg_write = 1'b1;
                state_d   = StFetch;
            end
            StTrap: begin
                state_d = StTrap;
            end
            default: begin
                state_d     = StTrap;
                illegal_set = 1'b1;
            end
        endcase
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (bus.mem_ready) begin
            wait_cnt_d = '0;
        end else if (is_wait_state(state_q) && (wait_cnt_q < MaxWaitW)) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
        if ((state_d != state_q) && is_wait_state(state_d)) begin
            wait_cnt_d = '0;
        end
    end

    // Reset forces outputs low combinationally, so they drop without waiting for a clock.
    assign bus.pc_write    = rst_n & pc_write;
    assign bus.pc_write_eq = rst_n & pc_write_eq;
    assign bus.pc_write_ne = rst_n & pc_write_ne;
    assign bus.iord        = rst_n & iord;
    assign bus.mem_read    = rst_n & mem_read;
    assign bus.mem_write   = rst_n & mem_write;
    assign bus.ir_write    = rst_n & ir_write;
    assign bus.mem_to_reg  = rst_n & mem_to_reg;
    assign bus.reg_dst     = rst_n & reg_dst;
    assign bus.reg_write   = rst_n & reg_write;
    assign bus.alu_src_a   = rst_n & alu_src_a;
    assign bus.alu_src_b   = rst_n ? alu_src_b : 2'b00;
    assign bus.alu_op      = rst_n ? alu_op : 2'b00;
    assign bus.pc_source   = rst_n ? pc_source : 2'b00;
    assign bus.illegal_op  = rst_n & illegal_q;
    assign bus.bus_timeout = rst_n & timeout_q;
    assign bus.state       = rst_n ? state_q : 4'd0;

endmodule

// File: tb/tb_mc_main_control.sv
// Scoreboard bench for mc_main_control: expected state and control vectors are queued
// as each cycle is driven and compared on the following falling edge.
module tb_mc_main_control;

    localparam int unsigned MaxWait = 4;

    localparam logic [5:0] OpR     = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpAddiu = 6'b001001;
    localparam logic [5:0] OpBad   = 6'b111111;

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [18:0] ctrl;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mc_main_control_if bus ();

    mc_main_control #(
        .WAIT_W   (8),
        .MAX_WAIT (MaxWait)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic       exp_ill = 1'b0;
    logic       exp_bto = 1'b0;
    logic [5:0] cur_op = 6'b0;
    string      cur_name = "";

    logic [18:0] act_ctrl;
    assign act_ctrl = {bus.pc_write, bus.pc_write_eq, bus.pc_write_ne, bus.iord, bus.mem_read,
                       bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write,
                       bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source,
                       bus.illegal_op, bus.bus_timeout};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Control fields per state: {pw, peq, pne, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb, ao, ps}
    function automatic logic [16:0] model(input logic [3:0] st, input logic [5:0] op,
                                          input logic mr);
        logic pw, peq, pne, iord, mrd, mwr, irw, m2r, rdst, rw, sa;
        logic [1:0] sb, ao, ps;
        {pw, peq, pne, iord, mrd, mwr, irw, m2r, rdst, rw, sa} = '0;
        sb = 2'b00;
        ao = 2'b00;
        ps = 2'b00;
        case (st)
            4'd0:  begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
            4'd1:  sb = 2'b11;
            4'd2:  begin sa = 1; sb = 2'b10; end
            4'd3:  begin mrd = 1; iord = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mwr = 1; iord = 1; end
            4'd6:  begin sa = 1; ao = 2'b11; end
            4'd7:  begin rw = 1; rdst = 1; end
            4'd8: begin
                sa = 1;
                ps = 2'b01;
                if (op == OpBne) begin ao = 2'b10; pne = 1; end
                else begin ao = 2'b01; peq = 1; end
            end
            4'd9:  begin pw = 1; ps = 2'b10; end
            4'd10: begin sa = 1; sb = 2'b10; end
            4'd11: rw = 1;
            default: ;
        endcase
        return {pw, peq, pne, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb, ao, ps};
    endfunction

    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.tag, " state"}, 32'(bus.state), 32'(e.st));
            check({e.tag, " ctrl"}, 32'(act_ctrl), 32'(e.ctrl));
        end
    end

    // One clock of stimulus; opcode is only meaningful in DECODE, so it is scrambled elsewhere.
    task automatic drive(input logic [3:0] st, input logic mr);
        exp_t e;
        bus.opcode    = (st == 4'd1) ? cur_op : 6'($urandom);
        bus.mem_ready = mr;
        e.tag  = $sformatf("%s st%0d", cur_name, st);
        e.st   = st;
        e.ctrl = {model(st, cur_op, mr), exp_ill, exp_bto};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic trap_cycles(input int n);
        for (int i = 0; i < n; i++) drive(4'd12, 1'($urandom));
    endtask

    task automatic wait_phase(input logic [3:0] st, input int n, output bit trapped);
        trapped = 1'b0;
        for (int i = 0; i < n; i++) begin
            drive(st, 1'b0);
            if (MaxWait != 0 && i + 1 == int'(MaxWait)) begin
                exp_bto = 1'b1;
                trapped = 1'b1;
                return;
            end
        end
    endtask

    task automatic run_instr(input string name, input logic [5:0] op, input int fw,
                             input int mw);
        bit tr;
        cur_name = name;
        cur_op   = op;
        wait_phase(4'd0, fw, tr);
        if (tr) begin trap_cycles(2); return; end
        drive(4'd0, 1'b1);
        drive(4'd1, 1'($urandom));
        case (op)
            OpLw: begin
                drive(4'd2, 1'($urandom));
                wait_phase(4'd3, mw, tr);
                if (tr) begin trap_cycles(2); return; end
                drive(4'd3, 1'b1);
                drive(4'd4, 1'($urandom));
            end
            OpSw: begin
                drive(4'd2, 1'($urandom));
                wait_phase(4'd5, mw, tr);
                if (tr) begin trap_cycles(2); return; end
                drive(4'd5, 1'b1);
            end
            OpR: begin
                drive(4'd6, 1'($urandom));
                drive(4'd7, 1'($urandom));
            end
            OpAddiu: begin
                drive(4'd10, 1'($urandom));
                drive(4'd11, 1'($urandom));
            end
            OpBeq, OpBne: drive(4'd8, 1'($urandom));
            OpJ: drive(4'd9, 1'($urandom));
            default: begin
                exp_ill = 1'b1;
                trap_cycles(3);
            end
        endcase
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, " rst state"}, 32'(bus.state), 32'd0);
        check({tag, " rst ctrl"}, 32'(act_ctrl), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_ill = 1'b0;
        exp_bto = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.opcode    = 6'b0;
        bus.mem_ready = 1'b0;
        do_reset("init");

        run_instr("lw", OpLw, 0, 0);
        run_instr("lw_wait3", OpLw, 0, 3);
        run_instr("sw", OpSw, 0, 0);
        run_instr("rtype", OpR, 0, 0);
        run_instr("addiu", OpAddiu, 0, 0);
        run_instr("beq", OpBeq, 0, 0);
        run_instr("bne", OpBne, 0, 0);
        run_instr("j", OpJ, 0, 0);
        run_instr("lw_fetchwait", OpLw, 2, 1);
        run_instr("sw_wait3", OpSw, 1, 3);
        run_instr("sw_timeout", OpSw, 0, 4);
        do_reset("after_timeout");

        run_instr("illegal", OpBad, 0, 0);
        do_reset("after_illegal");
        run_instr("fetch_timeout", OpR, 4, 0);
        do_reset("after_fetch_timeout");

        // Reset in the middle of a stalled store.
        cur_name = "sw_rst";
        cur_op   = OpSw;
        drive(4'd0, 1'b1);
        drive(4'd1, 1'b1);
        drive(4'd2, 1'b0);
        drive(4'd5, 1'b0);
        check("sw_rst mem_write before", 32'(bus.mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check("sw_rst mem_write async", 32'(bus.mem_write), 32'd0);
        do_reset("sw_rst");
        run_instr("r_after_rst", OpR, 0, 0);

        @(negedge clk);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
